mic1_exec_ctrl: RTL and testbench

Parametrised execution controller for the mic1 core and the successor to the run/step/stop FSM in the board top level. It drives the core's run enable from debounced button levels. Over the previous controller it adds:
- multi-instruction stepping with a runtime count
- hardware PC breakpoints with resume-past-breakpoint
- a halt input from the core
- a saturating executed-cycle counter
It sits between the debouncers and mic1_soc in every board top level.

---
 rtl/mic1_ctrl_pkg.sv | 19 +
 rtl/edge_detection.sv | 29 ++
 rtl/mic1_bp_match.sv | 30 +++
 rtl/mic1_exec_ctrl.sv | 149 ++++++++++++++
 tb/tb_mic1_exec_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mic1_ctrl_pkg.sv
// Shared types and default sizes for the mic1 execution controller.
//   exec_state_t : controller state, 3-bit, encodings visible on the state port
//   DEF_*        : default parameter values used by the controller modules
package mic1_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_STEP_WIDTH = 8;
    localparam int DEF_NUM_BP     = 2;
    localparam int DEF_CNT_WIDTH  = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_BREAK  = 3'd3,
        S_HALTED = 3'd4
    } exec_state_t;

endpackage

// File: rtl/edge_detection.sv
// Rising-edge detector for a debounced button level.
//   clk, resetn : clock, async active-low reset
//   sig         : level input
//   rise        : high for the cycle in which sig is seen going 0 -> 1
module edge_detection (
    input  logic clk,
    input  logic resetn,
    input  logic sig,
    output logic rise
);

    logic prev;
    logic armed;

    // The first clock after reset only samples the level, so a button held
    // through reset release is not mistaken for a fresh press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= sig;
            armed <= 1'b1;
        end
    end

    assign rise = armed & sig & ~prev;

endmodule

// File: rtl/mic1_bp_match.sv
// PC breakpoint comparator array with lowest-index priority.
//   pc      : current macro PC
//   bp_addr : packed breakpoint addresses, entry i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   bp_en   : per-entry enable
//   match   : any enabled entry equals pc
//   hit_vec : one-hot of the lowest matching entry (0 when no match)
module mic1_bp_match
    import mic1_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_BP     = DEF_NUM_BP
) (
    input  logic [ADDR_WIDTH-1:0]        pc,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]            bp_en,
    output logic                         match,
    output logic [NUM_BP-1:0]            hit_vec
);

    logic [NUM_BP-1:0] eq;

    for (genvar i = 0; i < NUM_BP; i++) begin : g_cmp
        assign eq[i] = bp_en[i] && (bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == pc);
    end

    assign match   = |eq;
    // Isolate the lowest set bit (x & -x).
    assign hit_vec = eq & (~eq + NUM_BP'(1));

endmodule

// File: rtl/mic1_exec_ctrl.sv
// Run/step/break/halt execution controller for the mic1 core.
//   clk, resetn      : clock, async active-low reset
//   btn_run/step/stop: debounced button levels (edges detected internally)
//   step_count       : macro-instructions per step (0 behaves as 1)
//   pc, instr_boundary, halt_req : core status
//   bp_addr, bp_en   : breakpoint table
//   cnt_clear        : synchronous clear of cycle_count
//   mic1_run         : core clock enable (combinational, drops in the stop cycle)
//   led_run, led_idle, state : status
//   bp_hit           : one-hot of last breakpoint hit, held until next run/step
//   step_done        : 1-cycle pulse after a step completes
//   cycle_count      : saturating count of cycles with mic1_run=1
module mic1_exec_ctrl
    import mic1_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int STEP_WIDTH = DEF_STEP_WIDTH,
    parameter int NUM_BP     = DEF_NUM_BP,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         btn_run,
    input  logic                         btn_step,
    input  logic                         btn_stop,
    input  logic [STEP_WIDTH-1:0]        step_count,
    input  logic [ADDR_WIDTH-1:0]        pc,
    input  logic                         instr_boundary,
    input  logic                         halt_req,
    input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
    input  logic [NUM_BP-1:0]            bp_en,
    input  logic                         cnt_clear,
    output logic                         mic1_run,
    output logic                         led_run,
    output logic                         led_idle,
    output logic [2:0]                   state,
    output logic [NUM_BP-1:0]            bp_hit,
    output logic                         step_done,
    output logic [CNT_WIDTH-1:0]         cycle_count
);

    exec_state_t           cur, nxt;
    logic [STEP_WIDTH-1:0] step_cnt, step_cnt_nxt;
    logic                  skip, skip_nxt;
    logic [NUM_BP-1:0]     bp_hit_nxt;
    logic                  done_nxt;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  run_e, step_e, stop_e;
    logic                  bp_match;
    logic [NUM_BP-1:0]     hit_vec;
    logic                  active, bp_stop, step_last, stop_now;

    edge_detection u_ed_run  (.clk(clk), .resetn(resetn), .sig(btn_run),  .rise(run_e));
    edge_detection u_ed_step (.clk(clk), .resetn(resetn), .sig(btn_step), .rise(step_e));
    edge_detection u_ed_stop (.clk(clk), .resetn(resetn), .sig(btn_stop), .rise(stop_e));

    mic1_bp_match #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_BP    (NUM_BP)
    ) u_bp (
        .pc     (pc),
        .bp_addr(bp_addr),
        .bp_en  (bp_en),
        .match  (bp_match),
        .hit_vec(hit_vec)
    );

    // Stop conditions are evaluated in the same cycle they appear so the core
    // gets no clock enable for the instruction that triggered them.
    assign active    = (cur == S_RUN) || (cur == S_STEP);
    assign bp_stop   = instr_boundary && bp_match && !skip;
    assign step_last = (cur == S_STEP) && instr_boundary && (step_cnt == STEP_WIDTH'(1));
    assign stop_now  = active && (halt_req || stop_e || bp_stop || step_last);

    assign mic1_run    = active && !stop_now;
    assign led_run     = active;
    assign led_idle    = (cur == S_IDLE) || (cur == S_BREAK);
    assign state       = cur;
    assign cycle_count = cnt_q;

    always_comb begin
        nxt          = cur;
        step_cnt_nxt = step_cnt;
        skip_nxt     = skip;
        bp_hit_nxt   = bp_hit;
        done_nxt     = 1'b0;
        case (cur)
            S_IDLE, S_BREAK: begin
                if (run_e) begin
                    nxt        = S_RUN;
                    skip_nxt   = (cur == S_BREAK);
                    bp_hit_nxt = '0;
                end else if (step_e) begin
                    nxt          = S_STEP;
                    step_cnt_nxt = (step_count == '0) ? STEP_WIDTH'(1) : step_count;
                    skip_nxt     = (cur == S_BREAK);
                    bp_hit_nxt   = '0;
                end
            end
            S_RUN, S_STEP: begin
                if (halt_req) begin
                    nxt = S_HALTED;
                end else if (stop_e) begin
                    nxt = S_IDLE;
                end else if (bp_stop) begin
                    nxt        = S_BREAK;
                    bp_hit_nxt = hit_vec;
                end else if (step_last) begin
                    nxt      = S_IDLE;
                    done_nxt = 1'b1;
                end else if (instr_boundary) begin
                    // First boundary after resuming consumes the skip.
                    skip_nxt = 1'b0;
                    if (cur == S_STEP)
                        step_cnt_nxt = step_cnt - STEP_WIDTH'(1);
                end
            end
            S_HALTED: nxt = S_HALTED;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur       <= S_IDLE;
            step_cnt  <= '0;
            skip      <= 1'b0;
            bp_hit    <= '0;
            step_done <= 1'b0;
        end else begin
            cur       <= nxt;
            step_cnt  <= step_cnt_nxt;
            skip      <= skip_nxt;
            bp_hit    <= bp_hit_nxt;
            step_done <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else if (cnt_clear)
            cnt_q <= '0;
        else if (mic1_run && !(&cnt_q))
            cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_mic1_exec_ctrl.sv
module tb_mic1_exec_ctrl;
    import mic1_ctrl_pkg::*;

    localparam int AW = 32;
    localparam int SW = 8;
    localparam int NB = 2;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            btn_run = 1'b0, btn_step = 1'b0, btn_stop = 1'b0;
    logic [SW-1:0]   step_count = '0;
    logic [AW-1:0]   pc = '0;
    logic            instr_boundary = 1'b0, halt_req = 1'b0, cnt_clear = 1'b0;
    logic [NB*AW-1:0] bp_addr = '0;
    logic [NB-1:0]   bp_en = '0;
    logic            mic1_run, led_run, led_idle, step_done;
    logic [2:0]      state;
    logic [NB-1:0]   bp_hit;
    logic [CW-1:0]   cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       run;
        logic       done;
        logic [2:0] st;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    mic1_exec_ctrl #(.ADDR_WIDTH(AW), .STEP_WIDTH(SW), .NUM_BP(NB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .btn_run(btn_run), .btn_step(btn_step), .btn_stop(btn_stop),
        .step_count(step_count), .pc(pc), .instr_boundary(instr_boundary), .halt_req(halt_req),
        .bp_addr(bp_addr), .bp_en(bp_en), .cnt_clear(cnt_clear), .mic1_run(mic1_run),
        .led_run(led_run), .led_idle(led_idle), .state(state), .bp_hit(bp_hit),
        .step_done(step_done), .cycle_count(cycle_count)
    );

    function automatic exp_t mk(logic r, logic d, exec_state_t s);
        exp_t x;
        x.run = r; x.done = d; x.st = s;
        return x;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (mic1_run !== 1'b0) begin n_bad++; $display("FAIL reset_run: got %b want 0", mic1_run); end
        n_cmp++; if (led_run !== 1'b0) begin n_bad++; $display("FAIL reset_led_run: got %b want 0", led_run); end
        n_cmp++; if (led_idle !== 1'b1) begin n_bad++; $display("FAIL reset_led_idle: got %b want 1", led_idle); end
        n_cmp++; if (bp_hit !== 2'b00) begin n_bad++; $display("FAIL reset_bp_hit: got %b want 00", bp_hit); end
        n_cmp++; if (step_done !== 1'b0) begin n_bad++; $display("FAIL reset_step_done: got %b want 0", step_done); end
        n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        tick(); resetn = 1'b1;
        tick(); tick();
    endtask

    task automatic test_run();
        exp_t e, g;
        for (int i = 0; i <= 42; i++) begin
            tick();
            btn_run        = (i <= 1);
            btn_stop       = (i == 41);
            instr_boundary = (i >= 2 && i <= 40 && (i % 2) == 0);
            pc             = 32'h100 + 32'(i);
            if (i == 0)       e = mk(1'b0, 1'b0, S_IDLE);
            else if (i <= 40) e = mk(1'b1, 1'b0, S_RUN);
            else if (i == 41) e = mk(1'b0, 1'b0, S_RUN);
            else              e = mk(1'b0, 1'b0, S_IDLE);
            q.push_back(e);
            @(negedge clk);
            g = q.pop_front();
            n_cmp++;
            if ({mic1_run, step_done, state} !== g) begin
                n_bad++;
                $display("FAIL run c%0d: got run=%b done=%b st=%0d want run=%b done=%b st=%0d",
                         i, mic1_run, step_done, state, g.run, g.done, g.st);
            end
        end
        n_cmp++; if (cycle_count !== 32'd40) begin n_bad++; $display("FAIL run_count: got %0d want 40", cycle_count); end
        btn_stop = 1'b0; instr_boundary = 1'b0;
    endtask

    task automatic test_step();
        exp_t e, g;
        // step_count=3, boundaries every 5 cycles: stop on the third.
        for (int i = 0; i <= 17; i++) begin
            tick();
            step_count     = 8'd3;
            btn_step       = (i == 0);
            instr_boundary = (i == 5 || i == 10 || i == 15);
            pc             = 32'h200 + 32'(i);
            e = mk((i >= 1 && i <= 14), (i == 16), (i >= 1 && i <= 15) ? S_STEP : S_IDLE);
            q.push_back(e);
            @(negedge clk);
            g = q.pop_front();
            n_cmp++;
            if ({mic1_run, step_done, state} !== g) begin
                n_bad++;
                $display("FAIL step3 c%0d: got run=%b done=%b st=%0d want run=%b done=%b st=%0d",
                         i, mic1_run, step_done, state, g.run, g.done, g.st);
            end
        end
        // step_count=0 behaves as 1.
        for (int i = 0; i <= 5; i++) begin
            tick();
            step_count     = 8'd0;
            btn_step       = (i == 0);
            instr_boundary = (i == 3);
            e = mk((i >= 1 && i <= 2), (i == 4), (i >= 1 && i <= 3) ? S_STEP : S_IDLE);
            q.push_back(e);
            @(negedge clk);
            g = q.pop_front();
            n_cmp++;
            if ({mic1_run, step_done, state} !== g) begin
                n_bad++;
                $display("FAIL step0 c%0d: got run=%b done=%b st=%0d want run=%b done=%b st=%0d",
                         i, mic1_run, step_done, state, g.run, g.done, g.st);
            end
        end
    endtask

    task automatic test_breakpoint();
        exp_t e, g;
        bp_en = 2'b10;
        bp_addr[0 +: AW]  = 32'h99;
        bp_addr[AW +: AW] = 32'h40;
        for (int i = 0; i <= 8; i++) begin
            tick();
            btn_run        = (i == 0 || i == 4);
            btn_stop       = (i == 7);
            instr_boundary = (i == 1 || i == 2 || i == 5 || i == 6);
            pc             = (i == 1) ? 32'h20 : (i == 6) ? 32'h44 : 32'h40;
            case (i)
                0:       e = mk(1'b0, 1'b0, S_IDLE);
                1:       e = mk(1'b1, 1'b0, S_RUN);
                2:       e = mk(1'b0, 1'b0, S_RUN);
                3, 4:    e = mk(1'b0, 1'b0, S_BREAK);
                5, 6:    e = mk(1'b1, 1'b0, S_RUN);
                7:       e = mk(1'b0, 1'b0, S_RUN);
                default: e = mk(1'b0, 1'b0, S_IDLE);
            endcase
            q.push_back(e);
            @(negedge clk);
            g = q.pop_front();
            n_cmp++;
            if ({mic1_run, step_done, state} !== g) begin
                n_bad++;
                $display("FAIL bp c%0d: got run=%b done=%b st=%0d want run=%b done=%b st=%0d",
                         i, mic1_run, step_done, state, g.run, g.done, g.st);
            end
            if (i == 3) begin
                n_cmp++; if (bp_hit !== 2'b10) begin n_bad++; $display("FAIL bp_hit: got %b want 10", bp_hit); end
            end
            if (i == 5) begin
                n_cmp++; if (bp_hit !== 2'b00) begin n_bad++; $display("FAIL bp_hit_clear: got %b want 00", bp_hit); end
            end
        end
        btn_stop = 1'b0; instr_boundary = 1'b0;
    endtask

    task automatic test_prio_halt();
        exp_t e, g;
        bp_en = 2'b11;
        bp_addr[0 +: AW]  = 32'h10;
        bp_addr[AW +: AW] = 32'h10;
        pc = 32'h10;
        for (int i = 0; i <= 9; i++) begin
            tick();
            btn_run        = (i == 0 || i == 3 || i == 7);
            btn_step       = (i == 8);
            step_count     = 8'd1;
            instr_boundary = (i == 1 || i == 4 || i == 5);
            halt_req       = (i >= 5);
            case (i)
                0:       e = mk(1'b0, 1'b0, S_IDLE);
                1:       e = mk(1'b0, 1'b0, S_RUN);
                2, 3:    e = mk(1'b0, 1'b0, S_BREAK);
                4:       e = mk(1'b1, 1'b0, S_RUN);
                5:       e = mk(1'b0, 1'b0, S_RUN);
                default: e = mk(1'b0, 1'b0, S_HALTED);
            endcase
            q.push_back(e);
            @(negedge clk);
            g = q.pop_front();
            n_cmp++;
            if ({mic1_run, step_done, state} !== g) begin
                n_bad++;
                $display("FAIL halt c%0d: got run=%b done=%b st=%0d want run=%b done=%b st=%0d",
                         i, mic1_run, step_done, state, g.run, g.done, g.st);
            end
            if (i == 2) begin
                n_cmp++; if (bp_hit !== 2'b01) begin n_bad++; $display("FAIL bp_lowest: got %b want 01", bp_hit); end
            end
            if (i == 6) begin
                n_cmp++;
                if ({led_run, led_idle} !== 2'b00) begin
                    n_bad++; $display("FAIL halt_leds: got %b%b want 00", led_run, led_idle);
                end
            end
        end
        tick();
        instr_boundary = 1'b0;
        halt_req = 1'b0;
        btn_step = 1'b0;
        resetn   = 1'b0;
        #2;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL halt_reset: got %0d want 0", state); end
        tick(); resetn = 1'b1;
        tick(); tick();
        bp_en = 2'b00;
    endtask

    task automatic test_simul_and_hold();
        exp_t e, g;
        for (int i = 0; i <= 5; i++) begin
            tick();
            step_count = 8'd5;
            btn_run    = (i == 0);
            btn_step   = (i == 0 || i == 2);
            btn_stop   = (i == 4);
            if (i <= 0)      e = mk(1'b0, 1'b0, S_IDLE);
            else if (i <= 3) e = mk(1'b1, 1'b0, S_RUN);
            else if (i == 4) e = mk(1'b0, 1'b0, S_RUN);
            else             e = mk(1'b0, 1'b0, S_IDLE);
            q.push_back(e);
            @(negedge clk);
            g = q.pop_front();
            n_cmp++;
            if ({mic1_run, step_done, state} !== g) begin
                n_bad++;
                $display("FAIL simul c%0d: got run=%b done=%b st=%0d want run=%b done=%b st=%0d",
                         i, mic1_run, step_done, state, g.run, g.done, g.st);
            end
        end
        // Run button held across reset release must not start the core.
        tick(); btn_stop = 1'b0; btn_run = 1'b1; resetn = 1'b0;
        tick(); tick(); resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            q.push_back(mk(1'b0, 1'b0, S_IDLE));
            @(negedge clk);
            g = q.pop_front();
            n_cmp++;
            if ({mic1_run, step_done, state} !== g) begin
                n_bad++;
                $display("FAIL hold c%0d: got run=%b st=%0d want run=%b st=%0d", i, mic1_run, state, g.run, g.st);
            end
        end
        tick(); btn_run = 1'b0;
        tick();
    endtask

    task automatic test_count_sat();
        tick();
        force dut.cnt_q = 32'hFFFF_FFFD;
        #2;
        release dut.cnt_q;
        for (int i = 0; i <= 8; i++) begin
            tick();
            btn_run   = (i == 0);
            cnt_clear = (i == 5);
            btn_stop  = (i == 7);
            @(negedge clk);
            if (i == 5) begin
                n_cmp++; if (cycle_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat: got %h want ffffffff", cycle_count); end
            end
            if (i == 6) begin
                n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL clear: got %h want 0", cycle_count); end
            end
            if (i == 7) begin
                n_cmp++; if (cycle_count !== 32'd1) begin n_bad++; $display("FAIL after_clear: got %h want 1", cycle_count); end
            end
        end
        btn_stop = 1'b0;
    endtask

    task automatic test_async_reset();
        tick(); step_count = 8'd10; btn_step = 1'b1;
        tick(); btn_step = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mic1_run, state} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL ar_pre: got run=%b st=%0d want run=1 st=2", mic1_run, state);
        end
        tick(); #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({mic1_run, led_run, state} !== {1'b0, 1'b0, 3'd0}) begin
            n_bad++; $display("FAIL ar_drop: got run=%b led=%b st=%0d want 0 0 0", mic1_run, led_run, state);
        end
        tick(); resetn = 1'b1;
        tick();
        n_cmp++; if (dut.step_cnt !== 8'd0) begin n_bad++; $display("FAIL ar_cnt: got %0d want 0", dut.step_cnt); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL ar_state: got %0d want 0", state); end
        tick();
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_breakpoint();
        test_prio_halt();
        test_simul_and_hold();
        test_count_sat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
